// File: rtl/instruction_issue_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module     : instruction_issue_controller_pkg
// Description: Shared constants and FSM encoding for the IF/ID issue controller.
// Revision   : 1.0 - initial release
// ============================================================================
package instruction_issue_controller_pkg;

  // Word substituted into ID on flush/bubble (and by the adjuster on reject)
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Issue FSM encoding
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/instruction_issue_controller_if.sv
`default_nettype none
// ============================================================================
// Module     : instruction_issue_controller_if
// Description: Fetch / hazard / adjuster / ID-stage bundle of the issue
//              controller. The master side is the surrounding pipeline, the
//              slave side is the controller.
// Revision   : 1.0 - initial release
// ============================================================================
interface instruction_issue_controller_if #(
  parameter int CNT_W = 8
);
  // Fetch side
  logic             if_valid;
  logic [31:0]      if_pc;
  logic [31:0]      if_instr;
  // Hazard unit / control
  logic             stall;
  logic             flush;
  logic             clear_log;
  // Adjuster path
  logic [31:0]      adj_instr_in;
  logic             adj_accepted;
  logic [31:0]      adj_instr_out;
  // Controller results
  logic             fetch_enable;
  logic             id_valid;
  logic [31:0]      id_pc;
  logic [31:0]      id_instr;
  logic             id_illegal;
  logic             halted;
  logic [CNT_W-1:0] illegal_count;
  logic [31:0]      first_illegal_pc;
  logic             first_illegal_vld;

  modport master (
    output if_valid, if_pc, if_instr, stall, flush, clear_log,
           adj_accepted, adj_instr_out,
    input  adj_instr_in, fetch_enable, id_valid, id_pc, id_instr, id_illegal,
           halted, illegal_count, first_illegal_pc, first_illegal_vld
  );

  modport slave (
    input  if_valid, if_pc, if_instr, stall, flush, clear_log,
           adj_accepted, adj_instr_out,
    output adj_instr_in, fetch_enable, id_valid, id_pc, id_instr, id_illegal,
           halted, illegal_count, first_illegal_pc, first_illegal_vld
  );

endinterface
`default_nettype wire

// File: rtl/instruction_issue_controller_illegal_event_log.sv
`default_nettype none
// ============================================================================
// Module     : illegal_event_log
// Description: Saturating illegal-issue counter with first-PC capture. A clear
//              coincident with an event is applied first, so the event becomes
//              the first entry of the fresh log.
// Revision   : 1.0 - initial release
// ============================================================================
module illegal_event_log
  import instruction_issue_controller_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear_i,
  input  logic             event_i,
  input  logic [31:0]      pc_i,
  output logic [CNT_W-1:0] count_o,
  output logic [CNT_W-1:0] count_next_o,
  output logic             bump_o,
  output logic [31:0]      first_pc_o,
  output logic             first_vld_o
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      pc_q, pc_d;
  logic             vld_q, vld_d;
  logic             bump_d;

  // Next-state: clear first, then fold in the event (saturating count)
  always_comb begin
    count_d = count_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    bump_d  = 1'b0;
    if (clear_i) begin
      count_d = '0;
      pc_d    = NOP_WORD;
      vld_d   = 1'b0;
    end
    if (event_i) begin
      if (count_d != C_CNT_MAX) begin
        count_d = count_d + CNT_W'(1);
        bump_d  = 1'b1;
      end
      if (!vld_d) begin
        pc_d  = pc_i;
        vld_d = 1'b1;
      end
    end
  end

  // Log registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      pc_q    <= '0;
      vld_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign bump_o       = bump_d;
  assign first_pc_o   = pc_q;
  assign first_vld_o  = vld_q;

endmodule
`default_nettype wire

// File: rtl/instruction_issue_controller.sv
`default_nettype none
// ============================================================================
// Module     : instruction_issue_controller
// Description: IF/ID stage controller. Routes the fetched word through the
//              legality adjuster, loads the ID register under flush/stall
//              control, logs rejected words and halts fetch after
//              MAX_ILLEGAL illegal issues (0 = never halt).
// Revision   : 1.0 - initial release
// ============================================================================
module instruction_issue_controller
  import instruction_issue_controller_pkg::*;
#(
  parameter int          CNT_W       = 8,
  parameter int unsigned MAX_ILLEGAL = 4
) (
  input logic                          clk,
  input logic                          reset_n,
  instruction_issue_controller_if.slave bus
);

  state_e           state_q;
  logic             id_valid_q;
  logic [31:0]      id_pc_q;
  logic [31:0]      id_instr_q;
  logic             id_illegal_q;

  logic             capture;
  logic             illegal_evt;
  logic             halt_trig;
  logic             log_bump;
  logic [CNT_W-1:0] log_count;
  logic [CNT_W-1:0] log_count_next;
  logic [31:0]      log_first_pc;
  logic             log_first_vld;

  // A word is taken only in RUN with no hazard request
  assign capture     = bus.if_valid & ~bus.stall & ~bus.flush & (state_q == ST_RUN);
  assign illegal_evt = capture & ~bus.adj_accepted;

  // Halt only on a real increment landing on the limit; a saturated count
  // no longer increments and so cannot re-trigger
  assign halt_trig = (MAX_ILLEGAL != 0) && log_bump &&
                     (32'(log_count_next) == MAX_ILLEGAL);

  illegal_event_log #(
    .CNT_W (CNT_W)
  ) u_log (
    .clk          (clk),
    .reset_n      (reset_n),
    .clear_i      (bus.clear_log),
    .event_i      (illegal_evt),
    .pc_i         (bus.if_pc),
    .count_o      (log_count),
    .count_next_o (log_count_next),
    .bump_o       (log_bump),
    .first_pc_o   (log_first_pc),
    .first_vld_o  (log_first_vld)
  );

  // RUN/HALT sequencing: halt on the limit, resume on clear_log
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:  if (halt_trig)     state_q <= ST_HALT;
        ST_HALT: if (bus.clear_log) state_q <= ST_RUN;
        default:                    state_q <= ST_RUN;
      endcase
    end
  end

  // ID register: flush > stall > capture > bubble
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_valid_q   <= 1'b0;
      id_pc_q      <= '0;
      id_instr_q   <= NOP_WORD;
      id_illegal_q <= 1'b0;
    end else if (bus.flush) begin
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_WORD;
      id_illegal_q <= 1'b0;
    end else if (bus.stall) begin
      id_valid_q   <= id_valid_q;
    end else if (capture) begin
      id_valid_q   <= 1'b1;
      id_pc_q      <= bus.if_pc;
      id_instr_q   <= bus.adj_instr_out;
      id_illegal_q <= ~bus.adj_accepted;
    end else begin
      id_valid_q   <= 1'b0;
      id_instr_q   <= NOP_WORD;
      id_illegal_q <= 1'b0;
    end
  end

  assign bus.adj_instr_in      = bus.if_instr;
  assign bus.fetch_enable      = (state_q == ST_RUN) & ~bus.stall;
  assign bus.halted            = (state_q == ST_HALT);
  assign bus.id_valid          = id_valid_q;
  assign bus.id_pc             = id_pc_q;
  assign bus.id_instr          = id_instr_q;
  assign bus.id_illegal        = id_illegal_q;
  assign bus.illegal_count     = log_count;
  assign bus.first_illegal_pc  = log_first_pc;
  assign bus.first_illegal_vld = log_first_vld;

endmodule
`default_nettype wire

// File: tb/tb_instruction_issue_controller.sv
`default_nettype none
// ============================================================================
// Module     : tb_instruction_issue_controller
// Description: Directed self-checking bench. DUT A: CNT_W=8, MAX_ILLEGAL=4.
//              DUT B: CNT_W=2, MAX_ILLEGAL=0 (saturation, never halts).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_instruction_issue_controller;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  logic [31:0] words [3] = '{32'h0000_0013, 32'h0010_0093, 32'h0020_8133};

  instruction_issue_controller_if #(.CNT_W(8)) a_if ();
  instruction_issue_controller_if #(.CNT_W(2)) b_if ();

  instruction_issue_controller #(.CNT_W(8), .MAX_ILLEGAL(4)) u_dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (a_if)
  );

  instruction_issue_controller #(.CNT_W(2), .MAX_ILLEGAL(0)) u_dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b_if)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic acc);
    a_if.if_valid      = v;
    a_if.if_pc         = pc;
    a_if.if_instr      = instr;
    a_if.adj_accepted  = acc;
    a_if.adj_instr_out = acc ? instr : 32'h0;
  endtask

  task automatic test_reset;
    #2;
    total++; if (a_if.id_valid !== 1'b0) begin bad++; $display("FAIL reset_id_valid got=%0b exp=0", a_if.id_valid); end
    total++; if (a_if.illegal_count !== 8'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_if.illegal_count); end
    total++; if (a_if.fetch_enable !== 1'b1) begin bad++; $display("FAIL reset_fetch_enable got=%0b exp=1", a_if.fetch_enable); end
    total++; if (a_if.halted !== 1'b0) begin bad++; $display("FAIL reset_halted got=%0b exp=0", a_if.halted); end
    total++; if (a_if.first_illegal_vld !== 1'b0) begin bad++; $display("FAIL reset_first_vld got=%0b exp=0", a_if.first_illegal_vld); end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_legal_stream;
    for (int i = 0; i < 3; i++) begin
      drive_a(1'b1, 32'h1000 + 32'(4 * i), words[i], 1'b1);
      #1;
      total++; if (a_if.adj_instr_in !== words[i]) begin bad++; $display("FAIL legal_adj_in[%0d] got=%h exp=%h", i, a_if.adj_instr_in, words[i]); end
      tick;
      total++; if (a_if.id_valid !== 1'b1) begin bad++; $display("FAIL legal_valid[%0d] got=%0b exp=1", i, a_if.id_valid); end
      total++; if (a_if.id_pc !== 32'h1000 + 32'(4 * i)) begin bad++; $display("FAIL legal_pc[%0d] got=%h exp=%h", i, a_if.id_pc, 32'h1000 + 32'(4 * i)); end
      total++; if (a_if.id_instr !== words[i]) begin bad++; $display("FAIL legal_instr[%0d] got=%h exp=%h", i, a_if.id_instr, words[i]); end
      total++; if (a_if.id_illegal !== 1'b0) begin bad++; $display("FAIL legal_illegal[%0d] got=%0b exp=0", i, a_if.id_illegal); end
    end
  endtask

  task automatic test_illegal;
    drive_a(1'b1, 32'h3004, 32'hFFFF_FFFF, 1'b0);
    tick;
    total++; if (a_if.id_instr !== 32'h0) begin bad++; $display("FAIL ill_instr got=%h exp=0", a_if.id_instr); end
    total++; if (a_if.id_illegal !== 1'b1) begin bad++; $display("FAIL ill_flag got=%0b exp=1", a_if.id_illegal); end
    total++; if (a_if.id_valid !== 1'b1) begin bad++; $display("FAIL ill_valid got=%0b exp=1", a_if.id_valid); end
    total++; if (a_if.illegal_count !== 8'd1) begin bad++; $display("FAIL ill_count1 got=%0d exp=1", a_if.illegal_count); end
    total++; if (a_if.first_illegal_pc !== 32'h3004) begin bad++; $display("FAIL ill_first_pc got=%h exp=3004", a_if.first_illegal_pc); end
    total++; if (a_if.first_illegal_vld !== 1'b1) begin bad++; $display("FAIL ill_first_vld got=%0b exp=1", a_if.first_illegal_vld); end
    drive_a(1'b1, 32'h3008, 32'h0000_0013, 1'b1);
    tick;
    drive_a(1'b1, 32'h3010, 32'hFFFF_0000, 1'b0);
    tick;
    total++; if (a_if.illegal_count !== 8'd2) begin bad++; $display("FAIL ill_count2 got=%0d exp=2", a_if.illegal_count); end
    total++; if (a_if.first_illegal_pc !== 32'h3004) begin bad++; $display("FAIL ill_first_pc_kept got=%h exp=3004", a_if.first_illegal_pc); end
    total++; if (a_if.id_pc !== 32'h3010) begin bad++; $display("FAIL ill_id_pc2 got=%h exp=3010", a_if.id_pc); end
  endtask

  task automatic test_stall_flush;
    drive_a(1'b1, 32'h4000, 32'h0000_0513, 1'b1);
    tick;
    drive_a(1'b1, 32'h4004, 32'h0000_0593, 1'b1);
    a_if.stall = 1'b1;
    #1;
    total++; if (a_if.fetch_enable !== 1'b0) begin bad++; $display("FAIL stall_fetch_en got=%0b exp=0", a_if.fetch_enable); end
    for (int i = 0; i < 2; i++) begin
      tick;
      total++; if (a_if.id_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%0b exp=1", i, a_if.id_valid); end
      total++; if (a_if.id_pc !== 32'h4000) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=4000", i, a_if.id_pc); end
      total++; if (a_if.id_instr !== 32'h0000_0513) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=00000513", i, a_if.id_instr); end
    end
    a_if.flush = 1'b1;
    tick;
    total++; if (a_if.id_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b exp=0", a_if.id_valid); end
    total++; if (a_if.id_instr !== 32'h0) begin bad++; $display("FAIL flush_instr got=%h exp=0", a_if.id_instr); end
    a_if.stall = 1'b0;
    a_if.flush = 1'b0;
    drive_a(1'b0, 32'h0, 32'h0, 1'b1);
    tick;
    total++; if (a_if.id_valid !== 1'b0) begin bad++; $display("FAIL bubble_valid got=%0b exp=0", a_if.id_valid); end
    total++; if (a_if.illegal_count !== 8'd2) begin bad++; $display("FAIL stall_count_kept got=%0d exp=2", a_if.illegal_count); end
  endtask

  task automatic test_halt;
    a_if.clear_log = 1'b1;
    tick;
    a_if.clear_log = 1'b0;
    total++; if (a_if.illegal_count !== 8'd0) begin bad++; $display("FAIL clr_count got=%0d exp=0", a_if.illegal_count); end
    total++; if (a_if.first_illegal_vld !== 1'b0) begin bad++; $display("FAIL clr_vld got=%0b exp=0", a_if.first_illegal_vld); end
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b1, 32'h5000 + 32'(4 * k), 32'hBAD0_0000, 1'b0);
      tick;
      total++; if (a_if.illegal_count !== 8'(k + 1)) begin bad++; $display("FAIL halt_count[%0d] got=%0d exp=%0d", k, a_if.illegal_count, k + 1); end
      total++; if (a_if.halted !== (k == 3)) begin bad++; $display("FAIL halt_flag[%0d] got=%0b exp=%0b", k, a_if.halted, (k == 3)); end
    end
    total++; if (a_if.fetch_enable !== 1'b0) begin bad++; $display("FAIL halt_fetch_en got=%0b exp=0", a_if.fetch_enable); end
    total++; if (a_if.id_valid !== 1'b1 || a_if.id_illegal !== 1'b1) begin bad++; $display("FAIL halt_trigger_id got=%0b%0b exp=11", a_if.id_valid, a_if.id_illegal); end
    total++; if (a_if.first_illegal_pc !== 32'h5000) begin bad++; $display("FAIL halt_first_pc got=%h exp=5000", a_if.first_illegal_pc); end
    drive_a(1'b1, 32'h5010, 32'h0000_0013, 1'b1);
    tick;
    total++; if (a_if.id_valid !== 1'b0) begin bad++; $display("FAIL halt_id_drop got=%0b exp=0", a_if.id_valid); end
    total++; if (a_if.illegal_count !== 8'd4) begin bad++; $display("FAIL halt_count_hold got=%0d exp=4", a_if.illegal_count); end
    a_if.clear_log = 1'b1;
    tick;
    a_if.clear_log = 1'b0;
    total++; if (a_if.halted !== 1'b0) begin bad++; $display("FAIL resume_halted got=%0b exp=0", a_if.halted); end
    total++; if (a_if.illegal_count !== 8'd0) begin bad++; $display("FAIL resume_count got=%0d exp=0", a_if.illegal_count); end
    total++; if (a_if.id_valid !== 1'b0) begin bad++; $display("FAIL resume_no_capture got=%0b exp=0", a_if.id_valid); end
    tick;
    total++; if (a_if.id_valid !== 1'b1 || a_if.id_pc !== 32'h5010) begin bad++; $display("FAIL resume_capture got=%0b/%h exp=1/5010", a_if.id_valid, a_if.id_pc); end
  endtask

  task automatic test_clear_coincident;
    drive_a(1'b1, 32'h6000, 32'hDEAD_0001, 1'b0);
    tick;
    total++; if (a_if.illegal_count !== 8'd1) begin bad++; $display("FAIL coin_pre_count got=%0d exp=1", a_if.illegal_count); end
    drive_a(1'b1, 32'h6100, 32'hDEAD_0002, 1'b0);
    a_if.clear_log = 1'b1;
    tick;
    a_if.clear_log = 1'b0;
    total++; if (a_if.illegal_count !== 8'd1) begin bad++; $display("FAIL coin_count got=%0d exp=1", a_if.illegal_count); end
    total++; if (a_if.first_illegal_pc !== 32'h6100) begin bad++; $display("FAIL coin_first_pc got=%h exp=6100", a_if.first_illegal_pc); end
    total++; if (a_if.first_illegal_vld !== 1'b1) begin bad++; $display("FAIL coin_vld got=%0b exp=1", a_if.first_illegal_vld); end
  endtask

  task automatic test_reset_mid;
    drive_a(1'b1, 32'h6200, 32'hDEAD_0003, 1'b0);
    tick;
    drive_a(1'b0, 32'h0, 32'h0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    total++; if (a_if.id_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%0b exp=0", a_if.id_valid); end
    total++; if (a_if.illegal_count !== 8'd0) begin bad++; $display("FAIL mid_rst_count got=%0d exp=0", a_if.illegal_count); end
    total++; if (a_if.first_illegal_vld !== 1'b0) begin bad++; $display("FAIL mid_rst_vld got=%0b exp=0", a_if.first_illegal_vld); end
    total++; if (a_if.fetch_enable !== 1'b1) begin bad++; $display("FAIL mid_rst_fetch_en got=%0b exp=1", a_if.fetch_enable); end
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_saturation;
    logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    for (int k = 0; k < 5; k++) begin
      b_if.if_valid      = 1'b1;
      b_if.if_pc         = 32'h7000 + 32'(4 * k);
      b_if.if_instr      = 32'hFFFF_FFFF;
      b_if.adj_accepted  = 1'b0;
      b_if.adj_instr_out = 32'h0;
      tick;
      total++; if (b_if.illegal_count !== exp_cnt[k]) begin bad++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", k, b_if.illegal_count, exp_cnt[k]); end
      total++; if (b_if.halted !== 1'b0) begin bad++; $display("FAIL sat_halted[%0d] got=%0b exp=0", k, b_if.halted); end
    end
    total++; if (b_if.first_illegal_pc !== 32'h7000) begin bad++; $display("FAIL sat_first_pc got=%h exp=7000", b_if.first_illegal_pc); end
    total++; if (b_if.id_illegal !== 1'b1 || b_if.fetch_enable !== 1'b1) begin bad++; $display("FAIL sat_id got=%0b/%0b exp=1/1", b_if.id_illegal, b_if.fetch_enable); end
    b_if.if_valid = 1'b0;
  endtask

  initial begin
    drive_a(1'b0, 32'h0, 32'h0, 1'b1);
    a_if.stall = 1'b0; a_if.flush = 1'b0; a_if.clear_log = 1'b0;
    b_if.if_valid = 1'b0; b_if.if_pc = 32'h0; b_if.if_instr = 32'h0;
    b_if.stall = 1'b0; b_if.flush = 1'b0; b_if.clear_log = 1'b0;
    b_if.adj_accepted = 1'b1; b_if.adj_instr_out = 32'h0;
    test_reset;
    test_legal_stream;
    test_illegal;
    test_stall_flush;
    test_halt;
    test_clear_coincident;
    test_reset_mid;
    test_saturation;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
